// File: rtl/s298_bist_ctrl_if.sv
// Control-side bundle of the s298 BIST controller: start/done handshake,
// golden signature in, verdict, signature, pattern count and FSM state out.
interface s298_bist_ctrl_if #(
  parameter int CNT_W = 11
);
  logic             start;
  logic [15:0]      golden_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      signature;
  logic [CNT_W-1:0] pattern_cnt;
  logic [2:0]       dbg_state;

  // Handshake: start is a one-cycle request honoured only while the controller
  // is idle or done (busy=0); busy stays high until the run drains, and done
  // plus pass then hold until the next accepted start.
  modport master (
    output start, golden_sig,
    input  busy, done, pass, signature, pattern_cnt, dbg_state
  );

  modport slave (
    input  start, golden_sig,
    output busy, done, pass, signature, pattern_cnt, dbg_state
  );
endinterface

// File: rtl/s298_bist_ctrl.sv
// BIST stage for the s298 core: LFSR pattern source on G0/G1/G2, MISR compaction
// of the six core outputs, and a start/done FSM that grades the signature.
module s298_bist_ctrl #(
  parameter int          NUM_PATTERNS = 1024,
  parameter int          INIT_CYCLES  = 2,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [15:0] POLY         = 16'hB400
) (
  input  logic             CK,
  input  logic             RN,
  s298_bist_ctrl_if.slave  ctl,
  output logic             dut_g0,
  output logic             dut_g1,
  output logic             dut_g2,
  input  logic             dut_g66,
  input  logic             dut_g67,
  input  logic             dut_g117,
  input  logic             dut_g118,
  input  logic             dut_g132,
  input  logic             dut_g133
);
  localparam int CNT_W  = $clog2(NUM_PATTERNS + 1);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_PATTERNS);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        misr_q, misr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INIT_W-1:0]  init_q, init_d;
  logic               cap_en_q;
  logic               g0_q, g1_q, g2_q;
  logic               g0_d, g1_d, g2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               issue;
  logic [5:0]         resp;
  logic [15:0]        misr_cap;

  function automatic logic [15:0] galois_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0000);
  endfunction

  assign resp     = {dut_g133, dut_g132, dut_g118, dut_g117, dut_g67, dut_g66};
  assign misr_cap = galois_step(misr_q) ^ {10'b0, resp};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = cap_en_q ? misr_cap : misr_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    pass_d  = pass_q;
    issue   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (ctl.start) begin
          state_d = INIT;
          lfsr_d  = SEED;
          misr_d  = '0;
          cnt_d   = '0;
          init_d  = '0;
          pass_d  = 1'b0;
        end
      end
      INIT: begin
        if (init_q == INIT_LAST) begin
          state_d = RUN;
          issue   = 1'b1;
        end else begin
          init_d = init_q + INIT_W'(1);
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DRAIN;
        else                   issue   = 1'b1;
      end
      DRAIN: begin
        // The final capture lands on this same edge, so grade the updated value.
        state_d = DONE;
        pass_d  = (misr_d == ctl.golden_sig);
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      lfsr_d = galois_step(lfsr_q);
      cnt_d  = cnt_q + CNT_W'(1);
    end

    // Core held in clear everywhere except while a pattern is being applied.
    g0_d = 1'b1;
    g1_d = 1'b0;
    g2_d = 1'b0;
    if (issue) begin
      g0_d = &lfsr_q[2:0];
      g1_d = lfsr_q[3];
      g2_d = lfsr_q[4];
    end

    busy_d = (state_d == INIT) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      misr_q   <= '0;
      cnt_q    <= '0;
      init_q   <= '0;
      cap_en_q <= 1'b0;
      g0_q     <= 1'b1;
      g1_q     <= 1'b0;
      g2_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      cap_en_q <= (state_q == RUN);
      g0_q     <= g0_d;
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_g0          = g0_q;
  assign dut_g1          = g1_q;
  assign dut_g2          = g2_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;
  assign ctl.pass        = pass_q;
  assign ctl.signature   = misr_q;
  assign ctl.pattern_cnt = cnt_q;
  assign ctl.dbg_state   = state_q;
endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Directed bench for s298_bist_ctrl with NUM_PATTERNS=4, INIT_CYCLES=2 and a
// stubbed core whose responses are selectable (all 0, all 1, or registered logic).
module tb_s298_bist_ctrl;
  localparam int NP    = 4;
  localparam int CNT_W = $clog2(NP + 1);

  logic CK;
  logic RN;
  logic dut_g0, dut_g1, dut_g2;
  logic dut_g66, dut_g67, dut_g117, dut_g118, dut_g132, dut_g133;

  s298_bist_ctrl_if #(.CNT_W(CNT_W)) bus ();

  s298_bist_ctrl #(
    .NUM_PATTERNS (NP),
    .INIT_CYCLES  (2),
    .SEED         (16'hACE1),
    .POLY         (16'hB400)
  ) dut (
    .CK       (CK),
    .RN       (RN),
    .ctl      (bus),
    .dut_g0   (dut_g0),
    .dut_g1   (dut_g1),
    .dut_g2   (dut_g2),
    .dut_g66  (dut_g66),
    .dut_g67  (dut_g67),
    .dut_g117 (dut_g117),
    .dut_g118 (dut_g118),
    .dut_g132 (dut_g132),
    .dut_g133 (dut_g133)
  );

  // ---------------- clock / reset ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // ---------------- core stub ----------------
  // Mode 2: flop-driven response {1, ~g0, g1^g2, g2, g1, g0} of the previous pattern.
  int         core_mode;
  logic [2:0] stub_q;
  logic [5:0] resp;

  always @(posedge CK) stub_q <= {dut_g2, dut_g1, dut_g0};

  always_comb begin
    resp = 6'b000000;
    case (core_mode)
      0:       resp = 6'b000000;
      1:       resp = 6'b111111;
      default: resp = {1'b1, ~stub_q[0], stub_q[1] ^ stub_q[2], stub_q[2], stub_q[1], stub_q[0]};
    endcase
  end

  assign {dut_g133, dut_g132, dut_g118, dut_g117, dut_g67, dut_g66} = resp;

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Per-cycle trace after edge n (n=1 is the edge that samples start).
  logic [4:0]  tr_ctl [0:15];  // {busy, done, g0, g1, g2}
  logic [15:0] tr_sig [0:15];

  task automatic run_once(input bit poke, output int lat);
    int n;
    @(negedge CK);
    bus.start = 1'b1;
    n   = 0;
    lat = 99;
    while (lat == 99 && n < 15) begin
      @(posedge CK);
      n++;
      @(negedge CK);
      // Stray starts during INIT, RUN and DRAIN must not disturb the run.
      bus.start  = poke && (n == 1 || n == 4 || n == 7);
      tr_ctl[n]  = {bus.busy, bus.done, dut_g0, dut_g1, dut_g2};
      tr_sig[n]  = bus.signature;
      if (bus.done) lat = n;
    end
    bus.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int lat;

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    RN             = 1'b0;
    bus.start      = 1'b0;
    bus.golden_sig = 16'h0000;
    core_mode      = 0;

    repeat (2) @(posedge CK);
    @(negedge CK);
    check_eq("rst_g0",    dut_g0, 1);
    check_eq("rst_g1g2",  {dut_g1, dut_g2}, 0);
    check_eq("rst_flags", {bus.busy, bus.done, bus.pass}, 0);
    check_eq("rst_sig",   bus.signature, 16'h0000);
    check_eq("rst_cnt",   bus.pattern_cnt, 0);
    check_eq("rst_state", bus.dbg_state, 0);
    RN = 1'b1;
    @(negedge CK);
    check_eq("idle_busy", bus.busy, 0);

    // Run A: all-zero responses, sequencing and first patterns.
    core_mode = 0;
    bus.golden_sig = 16'h0000;
    run_once(1'b0, lat);
    check_eq("a_latency", lat, 8);
    check_eq("a_init1",   tr_ctl[1], 5'b10100);
    check_eq("a_init2",   tr_ctl[2], 5'b10100);
    check_eq("a_pat0",    tr_ctl[3], 5'b10000);
    check_eq("a_pat1",    tr_ctl[4], 5'b10001);
    check_eq("a_drain",   tr_ctl[7], 5'b10100);
    check_eq("a_done",    tr_ctl[8], 5'b01100);
    check_eq("a_sig",     bus.signature, 16'h0000);
    check_eq("a_pass",    bus.pass, 1);
    check_eq("a_cnt",     bus.pattern_cnt, NP);

    // Run B: all-ones responses, restarted from DONE.
    core_mode = 1;
    bus.golden_sig = 16'h9928;
    run_once(1'b0, lat);
    check_eq("b_done_drop", tr_ctl[1][3], 0);
    check_eq("b_nocap",     tr_sig[4], 16'h0000);
    check_eq("b_cap1",      tr_sig[5], 16'h003F);
    check_eq("b_cap2",      tr_sig[6], 16'hB420);
    check_eq("b_cap3",      tr_sig[7], 16'h5A2F);
    check_eq("b_sig",       bus.signature, 16'h9928);
    check_eq("b_pass",      bus.pass, 1);
    check_eq("b_latency",   lat, 8);

    // Run C: golden off by one bit (LSB, then MSB).
    bus.golden_sig = 16'h9929;
    run_once(1'b0, lat);
    check_eq("c_lsb_pass", bus.pass, 0);
    check_eq("c_lsb_sig",  bus.signature, 16'h9928);
    bus.golden_sig = 16'h1928;
    run_once(1'b0, lat);
    check_eq("c_msb_pass", bus.pass, 0);
    check_eq("c_msb_done", bus.done, 1);

    // Run D: registered stub, stray starts during the run.
    core_mode = 2;
    bus.golden_sig = 16'h0024;
    run_once(1'b1, lat);
    check_eq("d_latency", lat, 8);
    check_eq("d_pat2",    tr_ctl[5], 5'b10011);
    check_eq("d_drain",   tr_ctl[7], 5'b10100);
    check_eq("d_cap1",    tr_sig[5], 16'h0030);
    check_eq("d_sig",     bus.signature, 16'h0024);
    check_eq("d_pass",    bus.pass, 1);
    repeat (3) @(negedge CK);
    check_eq("d_hold",    {bus.done, bus.pass, bus.busy}, 3'b110);
    check_eq("d_hold_cnt", bus.pattern_cnt, NP);

    // Repeat run gives the same signature.
    run_once(1'b0, lat);
    check_eq("e_sig",  bus.signature, 16'h0024);
    check_eq("e_pass", bus.pass, 1);

    // Asynchronous reset in the middle of RUN.
    @(negedge CK);
    bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    repeat (4) @(negedge CK);
    check_eq("r_pre_sig", bus.signature, 16'h0030);
    #2 RN = 1'b0;
    #1;
    check_eq("r_g0",    dut_g0, 1);
    check_eq("r_g1g2",  {dut_g1, dut_g2}, 0);
    check_eq("r_flags", {bus.busy, bus.done, bus.pass}, 0);
    check_eq("r_sig",   bus.signature, 16'h0000);
    check_eq("r_cnt",   bus.pattern_cnt, 0);
    @(negedge CK);
    RN = 1'b1;
    repeat (2) @(negedge CK);
    check_eq("r_idle",  {bus.busy, bus.done, bus.dbg_state}, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/s298_bist_ctrl.md
Name: s298_bist_ctrl

Overview:
Built-in self-test wrapper stage for the s298 sequential benchmark core and its camouflaged variants.
- Upstream side: a 16-bit LFSR generates pseudo-random patterns on the core inputs G0/G1/G2.
- Downstream side: a 16-bit MISR compacts the six core outputs (G66, G67, G117, G118, G132, G133) into a signature.
- A control FSM with a start/done handshake sequences the run and compares the signature against a golden value, so original and camouflaged netlists can be checked for functional equivalence.

Parameters:
NUM_PATTERNS, 1024, number of patterns applied in RUN; legal range is 1 or more.
INIT_CYCLES, 2, cycles G0 is held high to clear core state before RUN; legal range is 1 or more.
SEED, 16'hACE1, LFSR load value at start; must be nonzero.
POLY, 16'hB400, Galois feedback mask shared by the LFSR and the MISR.

Ports:
CK  input  1  clock; rising edge.
RN  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a run.
golden_sig  input  16  expected signature.
dut_g0  output  1  drives core G0 (clear).
dut_g1  output  1  drives core G1.
dut_g2  output  1  drives core G2.
dut_g66, dut_g67, dut_g117, dut_g118, dut_g132, dut_g133  input  1 each  core outputs.
busy  output  1  high from INIT through DRAIN.
done  output  1  high in DONE.
pass  output  1  signature equals golden_sig; meaningful only while done=1.
signature  output  16  current MISR contents.
pattern_cnt  output  clog2(NUM_PATTERNS+1)  number of patterns issued.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE; lfsr=SEED; misr=0; cnt=0; cap_en=0; dut_g0=1, dut_g1=0, dut_g2=0; busy=0; done=0; pass=0. Reset asserted mid-run aborts immediately to these values, with no partial signature retained.
- All outputs are registered. dut_g0 is 1 in IDLE, INIT and DONE, which keeps the core cleared.
- FSM states: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE, start=1: go to INIT; load lfsr=SEED, misr=0, cnt=0.
- INIT: hold for exactly INIT_CYCLES cycles with dut_g0=1, dut_g1=0, dut_g2=0, then go to RUN.
- RUN: each cycle drives dut_g0=(lfsr[2:0]==3'b111), dut_g1=lfsr[3], dut_g2=lfsr[4], all registered from the lfsr value at the preceding edge.
  - lfsr advances every RUN cycle: lfsr_next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - cnt increments per pattern. After NUM_PATTERNS RUN cycles, go to DRAIN.
- DRAIN: exactly 1 cycle, with dut_g0=1, then go to DONE.
- DONE: done=1; pass=(misr==golden_sig) is registered on entry and held. start=1 restarts exactly as from IDLE, with done dropping on the next cycle.
- Capture timing: cap_en is (state==RUN) delayed by one cycle. On each edge with cap_en=1, the MISR updates as misr_next = ((misr>>1) ^ (misr[0]?POLY:0)) ^ {10'b0, resp}, where resp = {g133,g132,g118,g117,g67,g66}.
  - Core outputs are flop-driven, so the response to pattern k is captured at the edge ending cycle k+1. Exactly NUM_PATTERNS captures occur; the last one falls in the DRAIN cycle.
- busy=1 in INIT, RUN and DRAIN. start while busy=1 is ignored.
- start and an FSM transition on the same edge: start is only sampled in IDLE and DONE.
- signature always mirrors misr. pattern_cnt saturates at NUM_PATTERNS until the next start.
- Total latency from start to done: 1 + INIT_CYCLES + NUM_PATTERNS + 1 cycles (start edge to done high).

Test Plan:
- Reset values: assert RN mid-RUN, release -> dut_g0=1, dut_g1=dut_g2=0, busy=done=pass=0, signature=16'h0000, pattern_cnt=0 within the same cycle as RN falling.
- Sequencing, NUM_PATTERNS=4, INIT_CYCLES=2: pulse start -> busy high next cycle, dut_g0=1 for 2 cycles, 4 RUN cycles, 1 DRAIN cycle, done high 8 cycles after the start edge.
- Pattern values: SEED=16'hACE1 -> first RUN pattern (g0,g1,g2)=(0,0,0); lfsr steps to 16'hE270 -> second pattern (0,0,1).
- MISR, with core outputs stubbed: all outputs 0 -> signature 16'h0000 at done. All outputs 1 -> 16'h003F after the first capture, 16'hB420 after the second.
- Golden compare: with the real s298 attached, golden_sig = model signature gives pass=1; any single-bit difference in golden_sig gives pass=0. The camouflaged netlist must reproduce the same signature.
- Handshake: start pulses during INIT, RUN and DRAIN are ignored and latency is unchanged. start in DONE restarts, giving an identical signature on a repeat run.
